// File: rtl/misr_sig_capture_pkg.sv
// Shared types and the MISR next-state function for the signature capture unit.
package misr_sig_capture_pkg;

  // Window controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Widest MISR the step function handles; callers zero-extend into this width.
  localparam int MAX_W = 64;

  // One MISR step on a zero-extended register.
  // Stage 0 takes the tap parity, every stage shifts up by one,
  // and lane i of din is folded into stage i.
  // Callers truncate the result back to their own WIDTH, which drops the
  // bit shifted out of the top stage.
  function automatic logic [MAX_W-1:0] misr_step(
    input logic [MAX_W-1:0] s,
    input logic [MAX_W-1:0] d,
    input logic [MAX_W-1:0] poly
  );
    logic fb;
    fb = ^(s & poly);
    return ((s << 1) | MAX_W'(fb)) ^ d;
  endfunction

endpackage

// File: rtl/misr_sig_capture_core.sv
// One MISR channel: loads SEED on load, steps on en, otherwise holds.
module misr_sig_capture_core
  import misr_sig_capture_pkg::*;
#(
  parameter int               WIDTH = 6,
  parameter int               DIN_W = 2,
  parameter logic [WIDTH-1:0] POLY  = 6'b110000,
  parameter logic [WIDTH-1:0] SEED  = 6'b000001
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [DIN_W-1:0] din,
  output logic [WIDTH-1:0] sig,
  output logic [WIDTH-1:0] sig_nxt
);

  // Parameter legality: lanes beyond the register length have no stage to feed.
  if (WIDTH < 2) begin : g_bad_width
    $error("misr_sig_capture_core: WIDTH must be at least 2");
  end
  if (WIDTH > MAX_W) begin : g_bad_max
    $error("misr_sig_capture_core: WIDTH exceeds MAX_W");
  end
  if (DIN_W < 1 || DIN_W > WIDTH) begin : g_bad_din
    $error("misr_sig_capture_core: DIN_W must be in 1..WIDTH");
  end

  // Next register value: seed load has priority, then a step, else hold.
  always_comb begin
    sig_nxt = sig;
    if (load) begin
      sig_nxt = SEED;
    end else if (en) begin
      sig_nxt = WIDTH'(misr_step(MAX_W'(sig), MAX_W'(din), MAX_W'(POLY)));
    end
  end

  // Signature register; reset returns it to SEED so no partial value survives.
  always_ff @(posedge clk) begin
    if (rst) begin
      sig <= SEED;
    end else begin
      sig <= sig_nxt;
    end
  end

endmodule

// File: rtl/misr_sig_capture.sv
// Multi-channel MISR signature capture: window FSM, beat counter,
// latched golden signatures and registered per-channel match flags.
module misr_sig_capture
  import misr_sig_capture_pkg::*;
#(
  parameter int               WIDTH  = 6,
  parameter int               DIN_W  = 2,
  parameter int               NUM_CH = 2,
  parameter logic [WIDTH-1:0] POLY   = 6'b110000,
  parameter logic [WIDTH-1:0] SEED   = 6'b000001,
  parameter int               CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [CNT_W-1:0]        len,
  input  logic                    din_vld,
  input  logic [NUM_CH*DIN_W-1:0] din,
  input  logic [NUM_CH*WIDTH-1:0] golden,
  output logic                    busy,
  output logic                    done,
  output logic [NUM_CH*WIDTH-1:0] sig,
  output logic [NUM_CH-1:0]       match
);

  if (NUM_CH < 1) begin : g_bad_ch
    $error("misr_sig_capture: NUM_CH must be at least 1");
  end
  if (CNT_W < 1) begin : g_bad_cnt
    $error("misr_sig_capture: CNT_W must be at least 1");
  end

  state_t                    state;
  state_t                    state_nxt;
  logic [CNT_W-1:0]          cnt;
  logic [CNT_W-1:0]          len_q;
  logic [NUM_CH*WIDTH-1:0]   golden_q;
  logic [NUM_CH*WIDTH-1:0]   golden_d;
  logic [NUM_CH*WIDTH-1:0]   sig_nxt;
  logic [NUM_CH-1:0]         match_d;
  logic                      start_acc;
  logic                      step;
  logic                      last;

  // start is only honoured outside a running window; abort wins over a beat.
  assign start_acc = start && (state != RUN);
  assign step      = (state == RUN) && din_vld && !abort;
  assign last      = step && (cnt == len_q - CNT_W'(1));

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // The golden set the window will be judged against after this edge.
  assign golden_d = start_acc ? golden : golden_q;

  // Channels are identical and step together under the shared controls.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    misr_sig_capture_core #(
      .WIDTH (WIDTH),
      .DIN_W (DIN_W),
      .POLY  (POLY),
      .SEED  (SEED)
    ) u_core (
      .clk     (clk),
      .rst     (rst),
      .load    (start_acc),
      .en      (step),
      .din     (din[c*DIN_W +: DIN_W]),
      .sig     (sig[c*WIDTH +: WIDTH]),
      .sig_nxt (sig_nxt[c*WIDTH +: WIDTH])
    );
  end

  // Compare each channel's upcoming signature with its upcoming golden value.
  always_comb begin
    match_d = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      match_d[c] = (sig_nxt[c*WIDTH +: WIDTH] == golden_d[c*WIDTH +: WIDTH]);
    end
  end

  // Window sequencing: a zero-length window goes straight to DONE.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: begin
        if (start_acc) begin
          state_nxt = (len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (last) begin
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, beat counter, latched window parameters and match flags.
  // match is loaded with the compare result whenever the next state is DONE;
  // inside DONE the inputs to that compare are frozen, so it holds its entry value.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      len_q    <= '0;
      golden_q <= '0;
      match    <= '0;
    end else begin
      state <= state_nxt;
      if (start_acc) begin
        cnt      <= '0;
        len_q    <= len;
        golden_q <= golden;
      end else if (step) begin
        cnt <= cnt + CNT_W'(1);
      end
      match <= (state_nxt == DONE) ? match_d : '0;
    end
  end

endmodule
